// File: rtl/dispense_actuator_if.sv
// rtl/dispense_actuator_if.sv - request, sensor and status bundle for the dispense actuator
interface dispense_actuator_if;
  logic       morningP;
  logic       afternoonP;
  logic       eveningP;
  logic       pill_sensor;
  logic       servo_pwm;
  logic       busy;
  logic [1:0] active_slot;
  logic       done;
  logic [2:0] fault;
  logic       overrun;

  // Scheduler / board side: issues requests, owns the sensor pin, reads status
  modport master (
    output morningP, afternoonP, eveningP, pill_sensor,
    input  servo_pwm, busy, active_slot, done, fault, overrun
  );

  // Actuator side
  modport slave (
    input  morningP, afternoonP, eveningP, pill_sensor,
    output servo_pwm, busy, active_slot, done, fault, overrun
  );
endinterface

// File: rtl/dispense_actuator.sv
// rtl/dispense_actuator.sv - queued per-slot servo dispense with sensor confirmation and retry
module dispense_actuator #(
  parameter int PWM_PERIOD   = 1000000,
  parameter int OPEN_W       = 100000,
  parameter int CLOSED_W     = 50000,
  parameter int OPEN_CYCLES  = 25000000,
  parameter int CLOSE_CYCLES = 25000000,
  parameter int MAX_RETRY    = 2
) (
  input logic               CLOCK_50,
  input logic               reset,
  dispense_actuator_if.slave bus
);

  // Pulse widths never exceed the frame, so one width covers counter and widths.
  localparam int TMAX = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(PWM_PERIOD + 1);
  localparam int AW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PWM_PERIOD - 1);
  localparam logic [FW-1:0] OPEN_WV    = FW'(OPEN_W);
  localparam logic [FW-1:0] CLOSED_WV  = FW'(CLOSED_W);
  localparam logic [AW-1:0] RETRY_MAX  = AW'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_CLOSE, S_DONE, S_FAULT} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [AW-1:0]   attempt, attempt_n;
  logic            seen, seen_n;
  logic [1:0]      slot_q, slot_n;
  logic [2:0]      pending, clr_mask, fault_q, fault_set, sel_mask;
  logic [1:0]      sel;
  logic            overrun_q, busy_q, done_q;
  logic            sync1, sync2, sprev, det;
  logic [FW-1:0]   frame_cnt, width_q;
  logic            pwm_q;
  logic [2:0]      req;

  assign req = {bus.eveningP, bus.afternoonP, bus.morningP};
  assign det = sync2 & ~sprev;

  assign bus.servo_pwm   = pwm_q;
  assign bus.busy        = busy_q;
  assign bus.active_slot = slot_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.overrun     = overrun_q;

  // Fixed priority pick among pending slots: 0 before 1 before 2
  always_comb begin
    sel      = 2'd2;
    sel_mask = 3'b100;
    if (pending[0]) begin
      sel      = 2'd0;
      sel_mask = 3'b001;
    end else if (pending[1]) begin
      sel      = 2'd1;
      sel_mask = 3'b010;
    end
  end

  // Next-state logic: open/close attempts, confirmation tracking and retry decision
  always_comb begin
    state_n   = state;
    timer_n   = timer + TW'(1);
    attempt_n = attempt;
    seen_n    = seen;
    slot_n    = slot_q;
    clr_mask  = 3'b000;
    fault_set = 3'b000;
    if ((state == S_OPEN || state == S_CLOSE) && det) seen_n = 1'b1;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (|pending) begin
          state_n   = S_OPEN;
          attempt_n = '0;
          seen_n    = 1'b0;
          slot_n    = sel;
          clr_mask  = sel_mask;
        end
      end
      S_OPEN: begin
        if (timer == OPEN_LAST) begin
          state_n = S_CLOSE;
          timer_n = '0;
        end
      end
      S_CLOSE: begin
        // The whole settle window always elapses, even if the pill was seen early
        if (timer == CLOSE_LAST) begin
          timer_n = '0;
          if (seen) begin
            state_n = S_DONE;
          end else if (attempt < RETRY_MAX) begin
            attempt_n = attempt + AW'(1);
            state_n   = S_OPEN;
          end else begin
            state_n = S_FAULT;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        timer_n = '0;
        slot_n  = 2'd3;
      end
      S_FAULT: begin
        state_n = S_IDLE;
        timer_n = '0;
        slot_n  = 2'd3;
        case (slot_q)
          2'd0:    fault_set = 3'b001;
          2'd1:    fault_set = 3'b010;
          2'd2:    fault_set = 3'b100;
          default: fault_set = 3'b000;
        endcase
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
        slot_n  = 2'd3;
      end
    endcase
  end

  // State register, request queue, sticky flags and registered status outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      attempt   <= '0;
      seen      <= 1'b0;
      slot_q    <= 2'd3;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending   <= 3'b000;
      fault_q   <= 3'b000;
      overrun_q <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      attempt <= attempt_n;
      seen    <= seen_n;
      slot_q  <= slot_n;
      busy_q  <= (state_n != S_IDLE);
      done_q  <= (state_n == S_DONE);
      pending <= (pending & ~clr_mask) | req;
      fault_q <= fault_q | fault_set;
      if (|(req & pending)) overrun_q <= 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous sensor plus a history flop for edge detect
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sprev <= 1'b0;
    end else begin
      sync1 <= bus.pill_sensor;
      sync2 <= sync1;
      sprev <= sync2;
    end
  end

  // Servo frame: width only changes at frame start so every pulse is a whole one
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      frame_cnt <= '0;
      width_q   <= CLOSED_WV;
      pwm_q     <= 1'b0;
    end else begin
      pwm_q <= (frame_cnt < width_q);
      if (frame_cnt == FRAME_LAST) frame_cnt <= '0;
      else                         frame_cnt <= frame_cnt + FW'(1);
      if (frame_cnt == '0) width_q <= (state == S_OPEN) ? OPEN_WV : CLOSED_WV;
    end
  end

endmodule

// File: tb/tb_dispense_actuator.sv
// tb/tb_dispense_actuator.sv - scoreboard bench for dispense_actuator
module tb_dispense_actuator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dispense_actuator_if bus();

  dispense_actuator #(
    .PWM_PERIOD(100), .OPEN_W(10), .CLOSED_W(5),
    .OPEN_CYCLES(50), .CLOSE_CYCLES(50), .MAX_RETRY(2)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .bus(bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];

  int  run = 0;
  int  since_rise = 0;
  bit  cut = 0;
  bit  norise = 1;
  bit  pwm_prev = 0;
  int  open_cnt = 0;
  int  closed_cnt = 0;

  task automatic check(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic check_ok(input string nm, input bit ok, input int act, input string exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %s", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] m);
    {bus.eveningP, bus.afternoonP, bus.morningP} = m;
    tick();
    {bus.eveningP, bus.afternoonP, bus.morningP} = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Counts busy cycles of one service, pulsing the sensor 20 clocks into OPEN
  // of every attempt numbered first_att or later.
  task automatic serve(input int first_att, output int n);
    n = 0;
    while (bus.busy && n < 1000) begin
      bus.pill_sensor = ((n % 100) >= 20) && ((n % 100) < 24) && ((n / 100) >= first_att);
      n++;
      tick();
    end
    bus.pill_sensor = 1'b0;
  endtask

  task automatic idle_for(input int cycles, output int b);
    b = 0;
    repeat (cycles) begin
      tick();
      if (bus.busy) b++;
    end
  endtask

  // Done monitor: each confirmed dispense must match the next expected slot
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) check_ok("done_unexpected", 1'b0, int'(bus.active_slot), "no done");
      else check("done_slot", int'(bus.active_slot), exp_q.pop_front());
    end
  end

  // PWM monitor: whole pulses of 5 or 10 clocks, rises exactly one frame apart
  always @(negedge clk) begin
    since_rise++;
    if (!rst) begin
      if (bus.servo_pwm) cut = 1;
      norise = 1;
    end else begin
      if (bus.servo_pwm && !pwm_prev) begin
        if (!norise) check("pwm_period", since_rise, 100);
        since_rise = 0;
        norise = 0;
        run = 0;
      end
      if (bus.servo_pwm) run++;
      if (!bus.servo_pwm && pwm_prev) begin
        if (!cut) begin
          check_ok("pwm_pulse_len", run == 5 || run == 10, run, "5 or 10");
          if (run == 10) open_cnt++;
          if (run == 5) closed_cnt++;
        end
        cut = 0;
      end
    end
    pwm_prev = bus.servo_pwm;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got %0d passed of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    int n, b, w, oc, cc;
    bus.morningP = 0; bus.afternoonP = 0; bus.eveningP = 0; bus.pill_sensor = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", bus.servo_pwm, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_slot", bus.active_slot, 3);
    check("rst_done", bus.done, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b1;
    repeat (5) tick();

    // Single success on slot 0
    exp_q.push_back(0);
    req(3'b001);
    check("s1_busy_t1", bus.busy, 0);
    tick();
    check("s1_busy_t2", bus.busy, 1);
    check("s1_slot", bus.active_slot, 0);
    serve(0, n);
    check("s1_busy_len", n, 101);
    check("s1_fault", bus.fault, 0);
    check("s1_idle_slot", bus.active_slot, 3);
    check("s1_q_empty", exp_q.size(), 0);

    // Priority and queueing: all three at once
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    req(3'b111);
    tick();
    check("s2_slot0", bus.active_slot, 0);
    serve(0, n);
    check("s2_len0", n, 101);
    check("s2_gap0_slot", bus.active_slot, 3);
    tick();
    check("s2_busy1", bus.busy, 1);
    check("s2_slot1", bus.active_slot, 1);
    serve(0, n);
    check("s2_len1", n, 101);
    check("s2_gap1_busy", bus.busy, 0);
    tick();
    check("s2_slot2", bus.active_slot, 2);
    serve(0, n);
    check("s2_len2", n, 101);
    idle_for(20, b);
    check("s2_no_more_service", b, 0);
    check("s2_q_empty", exp_q.size(), 0);

    // Retry exhaustion on slot 2
    req(3'b100);
    tick();
    check("s3_slot", bus.active_slot, 2);
    serve(99, n);
    check("s3_fault_len", n, 301);
    check("s3_fault", bus.fault, 3'b100);
    check("s3_q_empty", exp_q.size(), 0);

    // Success on the second attempt
    do_reset();
    check("s3_fault_cleared", bus.fault, 0);
    exp_q.push_back(2);
    req(3'b100);
    tick();
    serve(1, n);
    check("s3_retry_len", n, 201);
    check("s3_retry_fault", bus.fault, 0);
    check("s3_retry_q_empty", exp_q.size(), 0);

    // Overrun: slot 1 requested twice while slot 0 is in service
    exp_q.push_back(0); exp_q.push_back(1);
    req(3'b001);
    tick();
    req(3'b010);
    check("s4_overrun_first", bus.overrun, 0);
    req(3'b010);
    check("s4_overrun_second", bus.overrun, 1);
    serve(0, n);
    check("s4_len0", n, 99);
    tick();
    check("s4_slot1", bus.active_slot, 1);
    serve(0, n);
    check("s4_len1", n, 101);
    idle_for(20, b);
    check("s4_slot1_once", b, 0);
    check("s4_overrun_sticky", bus.overrun, 1);
    check("s4_q_empty", exp_q.size(), 0);

    // Reset while a pulse is high during OPEN
    req(3'b001);
    tick();
    w = 0;
    while (!bus.servo_pwm && w < 200) begin
      tick();
      w++;
    end
    check_ok("s5_pwm_high_seen", bus.servo_pwm && bus.busy, w, "pwm high while busy");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("s5_pwm", bus.servo_pwm, 0);
    check("s5_busy", bus.busy, 0);
    check("s5_slot", bus.active_slot, 3);
    check("s5_done", bus.done, 0);
    check("s5_fault", bus.fault, 0);
    check("s5_overrun", bus.overrun, 0);
    oc = open_cnt; cc = closed_cnt;
    idle_for(250, b);
    check("s5_no_service", b, 0);
    check("s5_closed_pulses", closed_cnt - cc, 3);
    check("s5_open_pulses", open_cnt - oc, 0);

    // Open width lands on a frame start that falls inside OPEN
    do_reset();
    repeat (59) tick();
    exp_q.push_back(0);
    oc = open_cnt;
    req(3'b001);
    tick();
    check("s6_busy", bus.busy, 1);
    serve(0, n);
    check("s6_len", n, 101);
    check("s6_open_pulses", open_cnt - oc, 1);
    repeat (120) tick();
    check("s6_final_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dispense_actuator.md
# dispense_actuator

Consumer end of the dispense-time pulses. Accepts one-cycle morning/afternoon/evening dispense requests and queues them per slot. Drives the dispenser servo through an open/close cycle and confirms each dispense with the pill-drop sensor on GPIO. Reports completion, per-slot fault, and overrun to the top level (LEDR/HEX).

## Interface
Parameters:
- PWM_PERIOD, 1000000: servo frame length in clocks (20 ms at 50 MHz).
- OPEN_W, 100000: high time in clocks for the open position (2 ms).
- CLOSED_W, 50000: high time in clocks for the closed position (1 ms).
- OPEN_CYCLES, 25000000: clocks held open per attempt.
- CLOSE_CYCLES, 25000000: clocks held closed after each attempt, used as the sensor settle window.
- MAX_RETRY, 2: extra attempts after the first before a fault is declared.

Ports:
- CLOCK_50, in, 1: sole clock.
- reset, in, 1: synchronous, active-low (driven from KEY[0]).
- morningP / afternoonP / eveningP, in, 1 each: one-cycle request pulses for slots 0, 1 and 2.
- pill_sensor, in, 1: asynchronous GPIO input; high while a pill is falling.
- servo_pwm, out, 1: servo control waveform.
- busy, out, 1: high in any state other than IDLE.
- active_slot, out, 2: slot being serviced (0, 1 or 2); 3 when idle.
- done, out, 1: one-cycle pulse on a confirmed dispense.
- fault, out, 3: sticky per-slot failure flags.
- overrun, out, 1: sticky flag; a request arrived for a slot that was already pending.

## Operation
- **Queue:** `pending[2:0]`. A request pulse sets its bit on the next edge.
  - If that bit is already 1, set `overrun`; the request is not double-queued.
  - Simultaneous pulses each set their own bit.
- **Arbitration:** in IDLE, priority is slot 0 > slot 1 > slot 2.
  - The selected bit is cleared on the IDLE→OPEN edge.
  - A new request for the active slot during service therefore queues normally.
- **Sensor path:** 2-flop synchronizer, then rising-edge detect. `det` = sync AND NOT previous sync.
- **States:**
  - IDLE: `active_slot` = 3. If any pending bit is set, go to OPEN, `attempt` = 0, timer = 0.
  - OPEN: servo width = OPEN_W. The timer counts to OPEN_CYCLES-1, then go to CLOSE with timer = 0.
  - CLOSE: servo width = CLOSED_W. The timer counts to CLOSE_CYCLES-1, then:
    - if `seen`, go to DONE;
    - else if `attempt` < MAX_RETRY, increment `attempt` and go to OPEN;
    - else go to FAULT.
  - DONE: assert `done` for 1 cycle, then IDLE.
  - FAULT: set `fault[active_slot]`, then IDLE. The slot's request is discarded.
- **`seen` flag:** cleared on entering OPEN from IDLE. Set by `det` in OPEN or CLOSE. Not cleared between retries.
  - An early `det` never shortens a state; the full CLOSE window always elapses.
- **`det` outside OPEN/CLOSE:** ignored.
- **PWM:**
  - Free-running frame counter 0..PWM_PERIOD-1.
  - `servo_pwm` = (frame count < latched width).
  - The width is latched only when the frame count = 0, so no runt pulses occur.
  - Latched width = OPEN_W when the state is OPEN, otherwise CLOSED_W.
- **Widths:**
  - Timer and frame counter are wide enough for their parameters.
  - `attempt` holds 0..MAX_RETRY.
  - No counter wraps in normal operation; the timer resets on every state change.
- **Reset (reset = 0 at an edge):** from any state, mid-actuation included:
  - state = IDLE, `pending` = 0, `fault` = 0, `overrun` = 0, `seen` = 0, `attempt` = 0, timer = 0, frame counter = 0, latched width = CLOSED_W, synchronizer = 0.
  - Outputs: `servo_pwm` = 0, `busy` = 0, `active_slot` = 3, `done` = 0.
  - Request pulses in the reset cycle are dropped.

## Timing
- Request pulse at edge t: pending visible at t+1. If idle, OPEN and `busy` = 1 from t+2.
- Sensor to `det`: 3 clocks.
- One attempt lasts OPEN_CYCLES + CLOSE_CYCLES clocks.
- Successful dispense: CLOSE→DONE on the last CLOSE clock; `done` high 1 cycle; IDLE the cycle after.
- Back-to-back requests: IDLE occupies exactly 1 cycle between services.
- Width change reaches `servo_pwm` at the next frame start, at most PWM_PERIOD clocks later.
- All outputs are registered.

## Test plan
All scenarios use PWM_PERIOD=100, OPEN_W=10, CLOSED_W=5, OPEN_CYCLES=CLOSE_CYCLES=50, MAX_RETRY=2.
- **Single success:** morningP pulse; sensor high 4 clocks at 20 clocks into OPEN → `active_slot`=0, one `done` pulse after 100 busy clocks, `fault`=000, return to IDLE.
- **Priority + queueing:** all three pulses in the same cycle, sensor pulsed every attempt → services run in slot order 0, 1, 2 with 1 idle cycle between; 3 `done` pulses; `pending`=000 at the end.
- **Retry then fault:** eveningP, sensor held low → 3 attempts (300 clocks), then `fault`=100, no `done`. Sensor pulse during attempt 2 instead → `done`, `fault`=000.
- **Overrun:** afternoonP twice while slot 0 is busy → `overrun`=1; slot 1 serviced exactly once.
- **Reset mid-OPEN:** reset low 1 cycle while `servo_pwm` is high → next cycle `servo_pwm`=0, `busy`=0, `active_slot`=3, `pending`/`fault`/`overrun`=0. The following frames show 5-clock pulses.
- **PWM integrity:** check `servo_pwm` over several frames → high exactly 5 of 100 clocks when closed, 10 of 100 when open; no partial pulse at OPEN/CLOSE transitions.
